// File: rtl/mem_pkg.sv
// Shared types for the read-modify-write memory controller: access sizes,
// controller states and the latched request payload.
package mem_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane datapath: extends the low bytes of a load sample and merges
// store bytes into the sampled memory word.
module mem_byte_lane
  import mem_pkg::*;
(
  input  size_e           size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] sample_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_ext_o,
  output logic [XLEN-1:0] store_merged_o
);

  logic sext_c;

  always_comb begin
    load_ext_o     = sample_i;
    store_merged_o = wdata_i;
    sext_c         = 1'b0;
    case (size_i)
      SZ_B: begin
        sext_c         = ~unsigned_i & sample_i[7];
        load_ext_o     = {{56{sext_c}}, sample_i[7:0]};
        store_merged_o = {sample_i[63:8], wdata_i[7:0]};
      end
      SZ_H: begin
        sext_c         = ~unsigned_i & sample_i[15];
        load_ext_o     = {{48{sext_c}}, sample_i[15:0]};
        store_merged_o = {sample_i[63:16], wdata_i[15:0]};
      end
      SZ_W: begin
        sext_c         = ~unsigned_i & sample_i[31];
        load_ext_o     = {{32{sext_c}}, sample_i[31:0]};
        store_merged_o = {sample_i[63:32], wdata_i[31:0]};
      end
      default: begin
        // Double: full sample on loads, full store data on stores.
        load_ext_o     = sample_i;
        store_merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Single-outstanding load/store controller for a 64-bit byte-banked memory;
// sub-double stores are done as read-modify-write.
module mem_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] mem_raddress,
  output logic [XLEN-1:0] mem_waddress,
  output logic [XLEN-1:0] mem_Datain,
  input  logic [XLEN-1:0] mem_Dataout,
  output logic            mem_Wr
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             lat_q, lat_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             wr_q, wr_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [XLEN-1:0]  datain_q, datain_d;
  logic [XLEN-1:0]  load_ext_c, store_merged_c;
  logic             accept_c;

  assign accept_c = (state_q == IDLE) && req_valid;

  mem_byte_lane u_lane (
    .size_i        (lat_q.size),
    .unsigned_i    (lat_q.uns),
    .sample_i      (mem_Dataout),
    .wdata_i       (lat_q.wdata),
    .load_ext_o    (load_ext_c),
    .store_merged_o(store_merged_c)
  );

  // State register and READ-phase counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (req_we && (size_e'(req_size) == SZ_D)) ? WRITE : READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (cnt_q == LAT_LAST) begin
          state_d = lat_q.we ? WRITE : RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and request-latch next values, aligned with the next state
  always_comb begin
    lat_d       = lat_q;
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    wr_d        = (state_d == WRITE);
    datain_d    = '0;
    rdata_d     = '0;
    if (accept_c) begin
      lat_d.we    = req_we;
      lat_d.size  = size_e'(req_size);
      lat_d.uns   = req_unsigned;
      lat_d.addr  = req_addr;
      lat_d.wdata = req_wdata;
    end
    if (state_d == WRITE) begin
      // A double store comes straight from IDLE with the live store data.
      datain_d = (state_q == IDLE) ? req_wdata : store_merged_c;
    end
    if ((state_d == RESP) && (state_q == READ)) begin
      rdata_d = load_ext_c;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lat_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      datain_q    <= '0;
    end else begin
      lat_q       <= lat_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      datain_q    <= datain_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign mem_raddress = lat_q.addr;
  assign mem_waddress = lat_q.addr;
  assign mem_Datain   = datain_q;
  // A reset landing on the WRITE cycle must not reach the memory.
  assign mem_Wr       = wr_q & ~Reset;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl at READ_LAT=1 and READ_LAT=3, each with its
// own byte-banked memory model.
module tb_mem_rmw_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        v1, v3;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr, req_wdata;

  logic        ready1, ready3, rspv1, rspv3, wr1, wr3;
  logic [63:0] rdata1, rdata3, raddr1, raddr3, waddr1, waddr3;
  logic [63:0] din1, din3, dout1, dout3;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem3 [256];
  logic [63:0] p3a, p3b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt1 = 0;
  int wr_cnt1 = 0;

  always #5 Clk = ~Clk;

  mem_rmw_ctrl #(.READ_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .req_valid(v1), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv1),
    .rsp_rdata(rdata1), .mem_raddress(raddr1), .mem_waddress(waddr1),
    .mem_Datain(din1), .mem_Dataout(dout1), .mem_Wr(wr1)
  );

  mem_rmw_ctrl #(.READ_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .req_valid(v3), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv3),
    .rsp_rdata(rdata3), .mem_raddress(raddr3), .mem_waddress(waddr3),
    .mem_Datain(din3), .mem_Dataout(dout3), .mem_Wr(wr3)
  );

  function automatic logic [63:0] rd1(input logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem1[8'(a + 64'(i))];
    return w;
  endfunction

  function automatic logic [63:0] rd3(input logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem3[8'(a + 64'(i))];
    return w;
  endfunction

  // Read-latency pipelines of the two memory models
  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    dout1 <= rd1(raddr1);
    p3a   <= rd3(raddr3);
    p3b   <= p3a;
    dout3 <= p3b;
    if (rspv1) rsp_cnt1 <= rsp_cnt1 + 1;
    if (wr1)   wr_cnt1  <= wr_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory writes are captured at the falling edge, away from DUT updates.
  task automatic tick();
    @(negedge Clk);
    if (wr1) for (int i = 0; i < 8; i++) mem1[8'(waddr1 + 64'(i))] = din1[8*i +: 8];
    if (wr3) for (int i = 0; i < 8; i++) mem3[8'(waddr3 + 64'(i))] = din3[8*i +: 8];
    @(posedge Clk);
    #1;
  endtask

  task automatic wr_mem1(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) mem1[8'(a + 64'(i))] = d[8*i +: 8];
  endtask

  task automatic wr_mem3(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) mem3[8'(a + 64'(i))] = d[8*i +: 8];
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd);
    req_we = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
  endtask

  // One access with exact pulse timing relative to the accept cycle.
  task automatic do_op(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd,
                       input int rsp_off, input int wr_off,
                       input logic [63:0] exp_rd, input logic [63:0] exp_din,
                       input string tag);
    set_req(w, sz, u, a, wd);
    if (sel) v3 = 1'b1; else v1 = 1'b1;
    chk({tag, ".ready_at_accept"}, 64'(sel ? ready3 : ready1), 64'(1));
    tick();
    v1 = 1'b0;
    v3 = 1'b0;
    for (int k = 1; k <= rsp_off; k++) begin
      chk({tag, ".rsp_valid"}, 64'(sel ? rspv3 : rspv1), 64'(k == rsp_off));
      chk({tag, ".mem_Wr"}, 64'(sel ? wr3 : wr1), 64'(k == wr_off));
      chk({tag, ".mem_Datain"}, sel ? din3 : din1, (k == wr_off) ? exp_din : 64'd0);
      chk({tag, ".raddress"}, sel ? raddr3 : raddr1, a);
      chk({tag, ".waddress"}, sel ? waddr3 : waddr1, a);
      if (k == rsp_off) chk({tag, ".rsp_rdata"}, sel ? rdata3 : rdata1, exp_rd);
      tick();
    end
    chk({tag, ".ready_after"}, 64'(sel ? ready3 : ready1), 64'(1));
    chk({tag, ".rsp_valid_after"}, 64'(sel ? rspv3 : rspv1), 64'(0));
  endtask

  initial begin
    int acc[$];
    int wr_base, rsp_base;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    wr_mem1(64'h10, 64'h1122334455667780);
    wr_mem1(64'h21, 64'hAABBCCDDEEFF0011);
    wr_mem1(64'hFF, 64'h0000000000009ABC);
    wr_mem3(64'h80, 64'h00000000F0000000);
    wr_mem3(64'h90, 64'h8877665544332211);
    v1 = 1'b0;
    v3 = 1'b0;
    set_req(1'b0, 2'b00, 1'b0, 64'h0, 64'h0);

    // Reset values
    Reset = 1'b1;
    tick();
    tick();
    chk("rst.ready", 64'(ready1), 64'(1));
    chk("rst.rsp_valid", 64'(rspv1), 64'(0));
    chk("rst.mem_Wr", 64'(wr1), 64'(0));
    Reset = 1'b0;
    tick();
    chk("rst.raddress", raddr1, 64'd0);
    chk("rst.waddress", waddr1, 64'd0);
    chk("rst.datain", din1, 64'd0);
    chk("rst.rdata", rdata1, 64'd0);
    chk("rst.ready3", 64'(ready3), 64'(1));

    // READ_LAT=1: loads respond at T+3, RMW stores write at T+3, doubles at T+1
    do_op(0, 0, 2'b00, 0, 64'h10, 64'h0, 3, -1, 64'hFFFFFFFFFFFFFF80, 64'h0, "ld_b_s");
    do_op(0, 1, 2'b01, 0, 64'h21, 64'h5566, 4, 3, 64'h0, 64'hAABBCCDDEEFF5566, "st_h");
    chk("st_h.mem", rd1(64'h21), 64'hAABBCCDDEEFF5566);
    do_op(0, 1, 2'b11, 0, 64'h40, 64'h0123456789ABCDEF, 2, 1, 64'h0, 64'h0123456789ABCDEF, "st_d");
    do_op(0, 0, 2'b10, 0, 64'h40, 64'h0, 3, -1, 64'hFFFFFFFF89ABCDEF, 64'h0, "ld_w_s");
    do_op(0, 0, 2'b11, 1, 64'h21, 64'h0, 3, -1, 64'hAABBCCDDEEFF5566, 64'h0, "ld_d");
    do_op(0, 0, 2'b00, 1, 64'h10, 64'h0, 3, -1, 64'h0000000000000080, 64'h0, "ld_b_u");
    do_op(0, 0, 2'b01, 1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3, -1, 64'h0000000000009ABC, 64'h0, "ld_h_u_wrap");
    do_op(0, 0, 2'b01, 0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3, -1, 64'hFFFFFFFFFFFF9ABC, 64'h0, "ld_h_s_wrap");
    do_op(0, 1, 2'b00, 0, 64'h10, 64'hFFFFFFFFFFFFFF7A, 4, 3, 64'h0, 64'h112233445566777A, "st_b");
    do_op(0, 1, 2'b10, 1, 64'h40, 64'h11111111CAFEF00D, 4, 3, 64'h0, 64'h01234567CAFEF00D, "st_w");
    chk("st_w.mem", rd1(64'h40), 64'h01234567CAFEF00D);

    // READ_LAT=3
    do_op(1, 0, 2'b10, 1, 64'h80, 64'h0, 5, -1, 64'h00000000F0000000, 64'h0, "l3_ld_w_u");
    do_op(1, 0, 2'b10, 0, 64'h80, 64'h0, 5, -1, 64'hFFFFFFFFF0000000, 64'h0, "l3_ld_w_s");
    do_op(1, 1, 2'b00, 0, 64'h90, 64'hAB, 6, 5, 64'h0, 64'h88776655443322AB, "l3_st_b");

    // Reset pulsed during READ of a store
    wr_base  = wr_cnt1;
    rsp_base = rsp_cnt1;
    set_req(1'b1, 2'b01, 1'b0, 64'h21, 64'h1234);
    v1 = 1'b1;
    chk("rst_rd.accept", 64'(ready1), 64'(1));
    tick();
    v1 = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_rd.ready", 64'(ready1), 64'(1));
    chk("rst_rd.mem_Wr", 64'(wr1), 64'(0));
    chk("rst_rd.raddress", raddr1, 64'd0);
    tick();
    chk("rst_rd.ready_next", 64'(ready1), 64'(1));
    for (int i = 0; i < 5; i++) tick();
    chk("rst_rd.wr_count", 64'(wr_cnt1 - wr_base), 64'd0);
    chk("rst_rd.rsp_count", 64'(rsp_cnt1 - rsp_base), 64'd0);
    chk("rst_rd.mem", rd1(64'h21), 64'hAABBCCDDEEFF5566);

    // Reset coinciding with the WRITE cycle
    set_req(1'b1, 2'b01, 1'b0, 64'h21, 64'h9999);
    v1 = 1'b1;
    chk("rst_wr.accept", 64'(ready1), 64'(1));
    tick();
    v1 = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_wr.mem_Wr", 64'(wr1), 64'(0));
    tick();
    Reset = 1'b0;
    chk("rst_wr.ready", 64'(ready1), 64'(1));
    for (int i = 0; i < 4; i++) tick();
    chk("rst_wr.wr_count", 64'(wr_cnt1 - wr_base), 64'd0);
    chk("rst_wr.rsp_count", 64'(rsp_cnt1 - rsp_base), 64'd0);
    chk("rst_wr.mem", rd1(64'h21), 64'hAABBCCDDEEFF5566);

    // req_valid held high across three loads
    rsp_base = rsp_cnt1;
    set_req(1'b0, 2'b00, 1'b0, 64'h10, 64'h0);
    v1 = 1'b1;
    for (int n = 0; n < 40 && acc.size() < 3; n++) begin
      if (ready1) acc.push_back(cyc);
      tick();
    end
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("hold.accepts", 64'(acc.size()), 64'd3);
    if (acc.size() == 3) begin
      chk("hold.gap1", 64'(acc[1] - acc[0]), 64'd4);
      chk("hold.gap2", 64'(acc[2] - acc[1]), 64'd4);
    end
    chk("hold.rsp_count", 64'(rsp_cnt1 - rsp_base), 64'd3);
    chk("hold.ready", 64'(ready1), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rmw_ctrl.md
MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 Parameter: READ_LAT, default 1, memory read latency in cycles from stable read address to valid data; legal range 1..3.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  requester has an access pending; held until accepted.
REQ-005 req_ready  output  1  controller can accept; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-008 req_unsigned  input  1  load zero-extend when 1, sign-extend when 0; ignored for stores.
REQ-009 req_addr  input  64  byte address; any alignment legal.
REQ-010 req_wdata  input  64  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  64  extended load data, valid with rsp_valid; 0 for stores.
REQ-013 mem_raddress  output  64  read address to the 64-bit byte-banked memory.
REQ-014 mem_waddress  output  64  write address to memory.
REQ-015 mem_Datain  output  64  write data to memory.
REQ-016 mem_Dataout  input  64  read data from memory, little-endian (bits 7:0 = byte at address).
REQ-017 mem_Wr  output  1  memory write enable.

Function
REQ-018 States SHALL be IDLE, READ, WRITE and RESP.
REQ-019 Handshake: accept SHALL occur on a cycle with req_valid=1 and state IDLE; addr, we, size, unsigned and wdata SHALL be latched on accept.
REQ-020 req_valid outside IDLE SHALL be ignored; there is no queueing.
REQ-021 mem_raddress and mem_waddress SHALL equal the latched address in every state, and 0 after reset.
REQ-022 Load or sub-double store: IDLE -> READ; READ SHALL last READ_LAT+1 cycles, with mem_Dataout sampled in its last cycle.
REQ-023 Load: READ -> RESP; accept at cycle T gives rsp_valid at T+READ_LAT+2.
REQ-024 Load extend: the low 8/16/32/64 bits of the sample SHALL be zero- or sign-extended to 64 bits per req_unsigned; double ignores req_unsigned.
REQ-025 Sub-double store: READ -> WRITE -> RESP; merged word = sample with its low 1/2/4 bytes replaced by the low bytes of wdata; mem_Wr at T+READ_LAT+2, rsp_valid at T+READ_LAT+3.
REQ-026 Double store SHALL skip READ: IDLE -> WRITE at T+1, RESP at T+2, with mem_Datain = wdata.
REQ-027 mem_Wr SHALL be 1 only in WRITE, for exactly one cycle per store; mem_Datain SHALL be 0 outside WRITE.
REQ-028 RESP SHALL last one cycle, then return to IDLE; req_ready SHALL rise the cycle after rsp_valid.
REQ-029 Address arithmetic SHALL NOT be performed; byte-bank wrap is owned by the memory.
REQ-030 Back-to-back: a request held high SHALL be accepted on the first IDLE cycle after RESP.

Reset
REQ-031 Reset SHALL force IDLE, the READ counter to 0, and all latched fields to 0.
REQ-032 Output reset values SHALL be: req_ready=1 and rsp_valid=0, mem_Wr=0, with all 64-bit outputs 0.
REQ-033 Reset asserted mid-operation SHALL abort the access with no mem_Wr and no rsp_valid; a reset coinciding with WRITE SHALL suppress that write.

Structure
REQ-034 A shared package mem_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W, SZ_D) and the state enum.
REQ-035 Extend and merge logic SHALL be one combinational sub-module mem_byte_lane (inputs: size, unsigned, sample, wdata; outputs: load_ext, store_merged).
REQ-036 The READ counter SHALL be 2 bits wide.

Verification
REQ-037 Load byte signed: mem[0x10..0x17]=0x1122334455667780, size=00, unsigned=0, READ_LAT=1, accept T -> rsp_valid at T+3, rsp_rdata=0xFFFFFFFFFFFFFF80.
REQ-038 Store half: mem[0x21..]=0xAABBCCDDEEFF0011, addr 0x21, wdata 0x5566 -> single mem_Wr at T+3 with mem_Datain=0xAABBCCDDEEFF5566 and waddress 0x21; rsp_valid at T+4.
REQ-039 Store double: addr 0x40, wdata 0x0123456789ABCDEF -> mem_Wr at T+1, rsp_valid at T+2, and no READ state visited.
REQ-040 Load word unsigned at READ_LAT=3: sample 0x00000000F0000000 -> rsp_rdata=0x00000000F0000000 at T+5.
REQ-041 Reset pulsed during READ of a store -> no mem_Wr ever, no rsp_valid, and req_ready=1 the cycle after reset deasserts.
REQ-042 req_valid held high for three loads -> accepts spaced READ_LAT+3 cycles apart, with exactly three rsp_valid pulses.
